l3_resp_tx: RTL

L3_RESP_TX -- requirements
Module: l3_resp_tx

---
 rtl/l3_pkg.sv | 35 +++
 rtl/l3_sync2.sv | 24 ++
 rtl/l3_resp_tx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/l3_pkg.sv
// Shared constants and types for the L3 SPI response transmitter.
// Build option: define L3_RESP_TX_PARITY_EN to append an odd-parity bit to each frame.
package l3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } tx_state_e;

  localparam int unsigned RESP_W = 8;
  localparam logic [RESP_W-1:0] IDLE_BYTE = 8'h00;

  // Response byte layout {head[1:0], err[1:0], res[3:0]}
  localparam int unsigned HEAD_LSB = 6;
  localparam int unsigned HEAD_W   = 2;
  localparam int unsigned ERR_LSB  = 4;
  localparam int unsigned ERR_W    = 2;
  localparam int unsigned RES_LSB  = 0;
  localparam int unsigned RES_W    = 4;

`ifdef L3_RESP_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 9;

  function automatic logic odd_parity(input logic [RESP_W-1:0] b);
    return ~^b;
  endfunction
`else
  localparam int unsigned FRAME_BITS = 8;
`endif

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/l3_sync2.sv
// Two-flop synchronizer with a selectable reset value.
module l3_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {2{RST_VAL}};
    else     sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/l3_resp_tx.sv
// SPI slave (mode 0) that serialises one core response byte per chip-select frame.
// Build option: L3_RESP_TX_PARITY_EN adds a trailing odd-parity bit (9-bit frames).
module l3_resp_tx
  import l3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_core,
  input  logic [7:0] core_resp,
  input  logic       core_resp_vld,
  output logic       resp_rdy,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic       tx_abort
);

  logic cs_s, sclk_s;

  l3_sync2 #(.RST_VAL(1'b1)) u_sync_cs (
    .clk (clk),
    .rst (rst),
    .d   (spi_cs_n),
    .q   (cs_s)
  );

  l3_sync2 #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk),
    .rst (rst),
    .d   (spi_sclk),
    .q   (sclk_s)
  );

  tx_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cs_p_q, cs_p_d;
  logic                  sclk_p_q, sclk_p_d;
  logic                  resp_rdy_q, resp_rdy_d;
  logic                  miso_q, miso_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic                  underrun_q, underrun_d;
  logic                  abort_q, abort_d;

  logic                  cs_fall_c, cs_rise_c, sclk_rise_c, sclk_fall_c;
  logic [RESP_W-1:0]     resp_word_c, load_byte_c;
  logic [FRAME_BITS-1:0] load_val_c;

  assign cs_fall_c   = cs_p_q & ~cs_s;
  assign cs_rise_c   = ~cs_p_q & cs_s;
  assign sclk_rise_c = ~sclk_p_q & sclk_s;
  assign sclk_fall_c = sclk_p_q & ~sclk_s;

  assign resp_word_c = {core_resp[HEAD_LSB +: HEAD_W],
                        core_resp[ERR_LSB +: ERR_W],
                        core_resp[RES_LSB +: RES_W]};
  assign load_byte_c = core_resp_vld ? resp_word_c : IDLE_BYTE;

`ifdef L3_RESP_TX_PARITY_EN
  assign load_val_c = {load_byte_c, odd_parity(load_byte_c)};
`else
  assign load_val_c = load_byte_c;
`endif

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    cs_p_d     = cs_s;
    sclk_p_d   = sclk_s;
    resp_rdy_d = 1'b0;
    underrun_d = 1'b0;
    abort_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall_c) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (cs_rise_c) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (clr_core) begin
          state_d = ST_HOLD;
          abort_d = 1'b1;
        end else begin
          shift_d    = load_val_c;
          cnt_d      = '0;
          resp_rdy_d = core_resp_vld;
          underrun_d = ~core_resp_vld;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_c) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (clr_core) begin
          state_d = ST_HOLD;
          abort_d = 1'b1;
        end else begin
          if (sclk_fall_c) shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
          if (sclk_rise_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (cs_rise_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    miso_d = (state_d == ST_SHIFT) & shift_d[FRAME_BITS-1];
    oe_d   = (state_d != ST_IDLE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      cs_p_q     <= 1'b1;
      sclk_p_q   <= 1'b0;
      resp_rdy_q <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      cs_p_q     <= cs_p_d;
      sclk_p_q   <= sclk_p_d;
      resp_rdy_q <= resp_rdy_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
    end
  end

  assign resp_rdy    = resp_rdy_q;
  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign tx_busy     = busy_q;
  assign tx_underrun = underrun_q;
  assign tx_abort    = abort_q;

endmodule
